mdu_seq: RTL

- Multi-cycle sequencer for the RV32M unit. It sits between the EX-stage issue logic and writeback.
- It accepts one M-extension op at a time through a valid/ready handshake.
- MUL* ops run through the external mul array and wait a fixed latency. DIV*/REM* ops run on an internal radix-2 restoring divider.
- It applies the RISC-V divide special cases, raises a stall while busy, and returns a single-cycle result pulse to writeback.

---
 rtl/mdu_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M sequencer (external mul array wait, radix-2 restoring divider)
// Ports: clk/rst_n (async active-low); i_valid/o_ready request handshake with i_ctrl, i_dataa, i_datab;
// i_flush aborts the in-flight op; o_busy stalls the pipeline; o_valid/o_result one-cycle result strobe;
// o_mul_a/o_mul_b/o_mul_s drive the external mul array, i_mul_prod returns its product.
// Build option: define MDU_EARLY_OUT_EN to skip the iteration loop when |dividend| < |divisor|.
module mdu_seq #(
  parameter int MUL_CYCLE = 1,
  parameter int DIV_ITER  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_ctrl,
  input  logic [31:0] i_dataa,
  input  logic [31:0] i_datab,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  output logic [1:0]  o_mul_s,
  input  logic [63:0] i_mul_prod
);
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE} state_t;
  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dvs;
  logic        rem_op_q, neg_q, neg_r, mul_hi;
  logic        accept, is_mul, is_div, sgn, rem_op, a_neg, b_neg, ovf, special, early, ge;
  logic [31:0] a_mag, b_mag, spec_res;
  logic [32:0] pr, diff;
  assign o_ready = state == IDLE;
  assign o_busy  = state != IDLE;
  assign o_valid = (state == DONE) & ~i_flush;
  assign accept  = i_valid & o_ready & ~i_flush;
  assign is_mul  = i_ctrl[3:2] == 2'b00;
  assign is_div  = i_ctrl inside {4'b0100, 4'b0101, 4'b0110, 4'b1011};
  assign sgn     = i_ctrl == 4'b0100 || i_ctrl == 4'b0110;
  assign rem_op  = i_ctrl == 4'b0110 || i_ctrl == 4'b1011;
  assign a_neg   = sgn & i_dataa[31];
  assign b_neg   = sgn & i_datab[31];
  assign a_mag   = a_neg ? -i_dataa : i_dataa;
  assign b_mag   = b_neg ? -i_datab : i_datab;
  assign ovf     = sgn && i_dataa == 32'h8000_0000 && i_datab == 32'hFFFF_FFFF;
  assign special = !is_div || i_datab == '0 || ovf;
  assign spec_res = !is_div ? '0 :
                    i_datab == '0 ? (rem_op ? i_dataa : 32'hFFFF_FFFF) :
                    ovf ? (rem_op ? '0 : 32'h8000_0000) : '0;
`ifdef MDU_EARLY_OUT_EN
  assign early = a_mag < b_mag;
`else
  assign early = 1'b0;
`endif
  // partial remainder is 33 bits wide so unsigned divisors above 2^31 compare correctly
  assign pr   = {rem, quo[31]};
  assign diff = pr - {1'b0, dvs};
  assign ge   = pr >= {1'b0, dvs};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      o_result <= '0;
      o_mul_a  <= '0;
      o_mul_b  <= '0;
      o_mul_s  <= '0;
      rem_op_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mul_hi   <= 1'b0;
    end else if (i_flush && state != IDLE) state <= IDLE;
    else case (state)
      IDLE: if (accept) begin
        rem_op_q <= rem_op;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        mul_hi   <= |i_ctrl[1:0];
        if (is_mul) begin
          o_mul_a <= i_dataa;
          o_mul_b <= i_datab;
          o_mul_s <= i_ctrl[1:0];
          cnt     <= 6'(MUL_CYCLE);
          state   <= MUL_WAIT;
        end else if (special) begin
          o_result <= spec_res;
          state    <= DONE;
        end else if (early) begin
          rem   <= a_mag;
          quo   <= '0;
          state <= DIV_FIX;
        end else begin
          rem   <= '0;
          quo   <= a_mag;
          dvs   <= b_mag;
          cnt   <= 6'(DIV_ITER);
          state <= DIV_RUN;
        end
      end
      MUL_WAIT: begin
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          o_result <= mul_hi ? i_mul_prod[63:32] : i_mul_prod[31:0];
          state    <= DONE;
        end
      end
      DIV_RUN: begin
        rem <= ge ? diff[31:0] : pr[31:0];
        quo <= {quo[30:0], ge};
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) state <= DIV_FIX;
      end
      DIV_FIX: begin
        o_result <= rem_op_q ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
        state    <= DONE;
      end
      DONE:    state <= IDLE;
      default: state <= IDLE;
    endcase
endmodule
